// File: rtl/sdp_ram_streamer_pkg.sv
// Shared types and width helpers for the RAM-to-AXI-Stream frame streamer.
package sdp_ram_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int fifo_depth);
        return $clog2(fifo_depth + 1);
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// First-word-fall-through FIFO with occupancy count.
// Latency: a written word is visible at rd_dat the cycle after the write edge.
// Backpressure: writer must respect count (no full flag); pop only when rd_vld && rd_rdy.
module stream_skid_fifo
    import sdp_ram_streamer_pkg::*;
#(
    parameter int DW    = 512,
    parameter int DEPTH = 4,
    parameter int CW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    output logic          rd_vld,
    output logic [DW-1:0] rd_dat,
    input  logic          rd_rdy,
    output logic [CW-1:0] count
);

    localparam int PW = addr_w(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_vld && rd_rdy;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(wr_vld) - CW'(pop);
        end
    end

endmodule

// File: rtl/sdp_ram_streamer.sv
// Reads FRAME_WORDS words from the RAM read port per start pulse and emits them as one AXI4-Stream frame.
// Latency: first TVALID RD_LAT+2 cycles after the start edge, then one beat per cycle.
// Backpressure: TREADY low holds the FIFO head; reads are throttled so in-flight plus queued never exceeds FIFO_DEPTH.
module sdp_ram_streamer
    import sdp_ram_streamer_pkg::*;
#(
    parameter int DW          = 512,
    parameter int DD          = 16384,
    parameter int FRAME_WORDS = DD,
    parameter int RD_LAT      = 2,
    parameter int FIFO_DEPTH  = RD_LAT + 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    output logic [addr_w(DD)-1:0] addrb,
    input  logic [DW-1:0]         dob,
    output logic                  busy,
    output logic                  overrun,
    output logic [31:0]           frame_count,
    output logic [DW-1:0]         AXIS_TDATA,
    output logic                  AXIS_TVALID,
    output logic                  AXIS_TLAST,
    input  logic                  AXIS_TREADY
);

    localparam int AW = addr_w(DD);
    localparam int CW = cnt_w(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_WORDS - 1);

    state_t            state;
    logic [RD_LAT-1:0] tag_pipe;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;
    logic [AW-1:0]     beat_idx;
    logic              issue;
    logic              tag_exit;
    logic              beat_hs;
    logic              last_hs;

    // Credit: every issued read owns a FIFO slot from issue until it is popped.
    assign issue    = (state == ISSUE) &&
                      (({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
    assign tag_exit = tag_pipe[RD_LAT-1];
    assign beat_hs  = AXIS_TVALID && AXIS_TREADY;
    assign AXIS_TLAST = AXIS_TVALID && (beat_idx == LAST_IDX);
    assign last_hs  = beat_hs && AXIS_TLAST;

    stream_skid_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .wr_vld (tag_exit),
        .wr_dat (dob),
        .rd_vld (AXIS_TVALID),
        .rd_dat (AXIS_TDATA),
        .rd_rdy (AXIS_TREADY),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_pipe <= '0;
            inflight <= '0;
            beat_idx <= '0;
        end else begin
            tag_pipe <= (tag_pipe << 1) | RD_LAT'(issue);
            inflight <= inflight + CW'(issue) - CW'(tag_exit);
            if (last_hs) begin
                beat_idx <= '0;
            end else if (beat_hs) begin
                beat_idx <= beat_idx + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            addrb       <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        addrb <= '0;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    // addrb parks on the last index so it never leaves the frame.
                    if (issue) begin
                        if (addrb == LAST_IDX) begin
                            state <= DRAIN;
                        end else begin
                            addrb <= addrb + AW'(1);
                        end
                    end
                    if (start) begin
                        overrun <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        frame_count <= frame_count + 32'd1;
                        if (start) begin
                            state <= ISSUE;
                            addrb <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (start) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdp_ram_streamer.sv
// Scoreboard bench: an 8-word/RD_LAT=2 streamer for the main scenarios and a 1-word/RD_LAT=4 corner instance.
module tb_sdp_ram_streamer;

    localparam int DW    = 32;
    localparam int DD    = 16;
    localparam int FW    = 8;
    localparam int LAT   = 2;
    localparam int DEPTH = LAT + 2;
    localparam int FW_C  = 1;
    localparam int LAT_C = 4;

    typedef struct {
        logic [DW-1:0] dat;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start_a, busy_a, overrun_a, tvalid_a, tlast_a, tready_a;
    logic [3:0]    addrb_a;
    logic [DW-1:0] dob_a, tdata_a;
    logic [31:0]   fc_a;
    logic          start_c, busy_c, overrun_c, tvalid_c, tlast_c, tready_c;
    logic [3:0]    addrb_c;
    logic [DW-1:0] dob_c, tdata_c;
    logic [31:0]   fc_c;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t sb_q[$];
    beat_t mon_exp;
    int    beats_seen = 0;
    int    acc_cnt    = 0;
    bit    credit_on  = 1'b0;
    bit    bp_on      = 1'b0;
    bit    hold_pend  = 1'b0;
    logic [DW-1:0] hold_dat;

    always #5 clk = ~clk;

    sdp_ram_streamer #(.DW(DW), .DD(DD), .FRAME_WORDS(FW), .RD_LAT(LAT)) dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .addrb(addrb_a), .dob(dob_a),
        .busy(busy_a), .overrun(overrun_a), .frame_count(fc_a),
        .AXIS_TDATA(tdata_a), .AXIS_TVALID(tvalid_a), .AXIS_TLAST(tlast_a), .AXIS_TREADY(tready_a)
    );

    sdp_ram_streamer #(.DW(DW), .DD(DD), .FRAME_WORDS(FW_C), .RD_LAT(LAT_C)) dut_c (
        .clk(clk), .resetn(resetn), .start(start_c), .addrb(addrb_c), .dob(dob_c),
        .busy(busy_c), .overrun(overrun_c), .frame_count(fc_c),
        .AXIS_TDATA(tdata_c), .AXIS_TVALID(tvalid_c), .AXIS_TLAST(tlast_c), .AXIS_TREADY(tready_c)
    );

    // RAM models with RAM[i] = i: read data appears RD_LAT cycles after the address.
    logic [3:0] ra_pipe [LAT];
    logic [3:0] rc_pipe [LAT_C];
    always @(posedge clk) begin
        ra_pipe[0] <= addrb_a;
        for (int i = 1; i < LAT; i++) ra_pipe[i] <= ra_pipe[i-1];
        rc_pipe[0] <= addrb_c;
        for (int j = 1; j < LAT_C; j++) rc_pipe[j] <= rc_pipe[j-1];
    end
    assign dob_a = {28'd0, ra_pipe[LAT-1]};
    assign dob_c = {28'd0, rc_pipe[LAT_C-1]};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < FW; i++) begin
            sb_q.push_back('{dat: DW'(i), last: (i == FW - 1)});
        end
    endtask

    task automatic pulse_start_a();
        @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output int n);
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_done", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (beats_seen < target && n < 100) begin
            step();
            n++;
        end
        check_eq("beat_wait", 64'(beats_seen >= target), 64'd1);
    endtask

    // Back-pressure driver: random TREADY while bp_on, otherwise always ready.
    initial begin
        tready_a = 1'b1;
        forever begin
            @(posedge clk);
            #1 tready_a = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor for instance A.
    always @(negedge clk) begin
        if (!resetn) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check_eq("hold_vld", 64'(tvalid_a), 64'd1);
                check_eq("hold_dat", 64'(tdata_a), 64'(hold_dat));
                hold_pend = 1'b0;
            end
            if (credit_on && busy_a) begin
                check_eq("credit", 64'(int'(addrb_a) <= acc_cnt + DEPTH), 64'd1);
                check_eq("addrb_range", 64'(int'(addrb_a) <= FW - 1), 64'd1);
            end
            if (tvalid_a && tready_a) begin
                check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    mon_exp = sb_q.pop_front();
                    check_eq("tdata", 64'(tdata_a), 64'(mon_exp.dat));
                    check_eq("tlast", 64'(tlast_a), 64'(mon_exp.last));
                end
                acc_cnt++;
                beats_seen++;
            end else if (tvalid_a) begin
                hold_pend = 1'b1;
                hold_dat  = tdata_a;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k, n, base, busy_low, exp_frames;
        resetn  = 1'b0;
        start_a = 1'b0;
        start_c = 1'b0;
        tready_c = 1'b1;
        repeat (3) step();
        check_eq("rst_addrb", 64'(addrb_a), 64'd0);
        check_eq("rst_busy", 64'(busy_a), 64'd0);
        check_eq("rst_overrun", 64'(overrun_a), 64'd0);
        check_eq("rst_fc", 64'(fc_a), 64'd0);
        check_eq("rst_tvalid", 64'(tvalid_a), 64'd0);
        check_eq("rst_tlast", 64'(tlast_a), 64'd0);
        check_eq("rst_c_busy", 64'(busy_c), 64'd0);
        check_eq("rst_c_tvalid", 64'(tvalid_c), 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        exp_frames = 0;

        // Free-running frame: latency, contiguous beats, frame end.
        push_frame();
        pulse_start_a();
        k = 0;
        do begin
            step();
            k++;
        end while (!tvalid_a && k < 20);
        check_eq("first_vld_lat", 64'(k), 64'(LAT + 2));
        wait_drain(100, n);
        check_eq("stream_cycles", 64'(n), 64'(FW - 1));
        step();
        exp_frames++;
        check_eq("t1_busy_end", 64'(busy_a), 64'd0);
        check_eq("t1_fc", 64'(fc_a), 64'(exp_frames));
        check_eq("t1_tvalid_end", 64'(tvalid_a), 64'd0);

        // Random back-pressure, two frames.
        for (int f = 0; f < 2; f++) begin
            bp_on     = 1'b1;
            credit_on = 1'b1;
            acc_cnt   = 0;
            push_frame();
            pulse_start_a();
            wait_drain(400, n);
            bp_on     = 1'b0;
            credit_on = 1'b0;
            step();
            exp_frames++;
            check_eq("bp_busy_end", 64'(busy_a), 64'd0);
            check_eq("bp_fc", 64'(fc_a), 64'(exp_frames));
        end

        // Overrun: extra start mid-frame is ignored.
        base = beats_seen;
        push_frame();
        pulse_start_a();
        wait_beats(base + 4);
        @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        step();
        check_eq("overrun_pulse", 64'(overrun_a), 64'd1);
        step();
        check_eq("overrun_clear", 64'(overrun_a), 64'd0);
        wait_drain(100, n);
        step();
        exp_frames++;
        check_eq("ovr_fc", 64'(fc_a), 64'(exp_frames));
        check_eq("ovr_busy_end", 64'(busy_a), 64'd0);
        repeat (6) step();
        check_eq("ovr_no_extra", 64'(tvalid_a), 64'd0);

        // Back-to-back: second start coincides with the TLAST handshake.
        busy_low = 0;
        push_frame();
        pulse_start_a();
        repeat (10) begin
            step();
            if (!busy_a) busy_low++;
        end
        @(posedge clk);
        #1 start_a = 1'b1;
        push_frame();
        step();
        check_eq("b2b_tlast_cycle", 64'({tvalid_a, tlast_a}), 64'd3);
        @(posedge clk);
        #1 start_a = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            step();
            n++;
            if (sb_q.size() != 0 && !busy_a) busy_low++;
        end
        check_eq("b2b_drain", 64'(sb_q.size()), 64'd0);
        check_eq("b2b_busy_held", 64'(busy_low), 64'd0);
        step();
        exp_frames += 2;
        check_eq("b2b_fc", 64'(fc_a), 64'(exp_frames));
        check_eq("b2b_busy_end", 64'(busy_a), 64'd0);

        // Reset in the middle of a frame.
        base = beats_seen;
        push_frame();
        pulse_start_a();
        wait_beats(base + 5);
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check_eq("mid_rst_tvalid", 64'(tvalid_a), 64'd0);
        check_eq("mid_rst_busy", 64'(busy_a), 64'd0);
        check_eq("mid_rst_addrb", 64'(addrb_a), 64'd0);
        check_eq("mid_rst_fc", 64'(fc_a), 64'd0);
        sb_q.delete();
        exp_frames = 0;
        step();
        @(posedge clk);
        #1 resetn = 1'b1;
        push_frame();
        pulse_start_a();
        wait_drain(100, n);
        step();
        exp_frames++;
        check_eq("post_rst_fc", 64'(fc_a), 64'(exp_frames));
        check_eq("post_rst_busy", 64'(busy_a), 64'd0);

        // Corner: single-word frame with RD_LAT=4.
        @(posedge clk);
        #1 start_c = 1'b1;
        @(posedge clk);
        #1 start_c = 1'b0;
        k = 0;
        do begin
            step();
            k++;
        end while (!tvalid_c && k < 20);
        check_eq("c_first_vld_lat", 64'(k), 64'(LAT_C + 2));
        check_eq("c_tdata", 64'(tdata_c), 64'd0);
        check_eq("c_tlast", 64'(tlast_c), 64'd1);
        step();
        check_eq("c_tvalid_end", 64'(tvalid_c), 64'd0);
        check_eq("c_busy_end", 64'(busy_c), 64'd0);
        check_eq("c_fc", 64'(fc_c), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
